// File: rtl/clk_div3_trio.sv
// clk_div3_trio: divide-by-3 clock generator with 1/3, 2/3 and 50% duty outputs
// All outputs derive from one mod-3 counter, so they stay phase-locked.
module clk_div3_trio (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out_1_3,
    output logic clk_out_2_3,
    output logic clk_out_1_2
);
    logic [1:0] cnt;
    logic       p;
    logic       n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 2'd0;
            clk_out_1_3 <= 1'b0;
            clk_out_2_3 <= 1'b0;
            p           <= 1'b0;
        end else begin
            cnt         <= (cnt >= 2'd2) ? 2'd0 : cnt + 2'd1;
            clk_out_1_3 <= cnt == 2'd2;
            clk_out_2_3 <= cnt != 2'd2;
            p           <= cnt == 2'd2;
        end
    end
    // Half-cycle delayed copy of p stretches the pulse to 1.5 cycles
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) n <= 1'b0;
        else        n <= p;
    end
    assign clk_out_1_2 = p | n;
endmodule

// File: tb/tb_clk_div3_trio.sv
// tb_clk_div3_trio: randomized self-checking bench for clk_div3_trio
// Reference model works from the number of posedges seen since reset release.
module tb_clk_div3_trio;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_out_1_3, clk_out_2_3, clk_out_1_2;
    int   errors = 0;
    int   checks = 0;
    int   k = 0;
    bit   rec = 1'b0;
    longint r13[$], r23[$], r12[$], f12[$];

    clk_div3_trio dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_out_1_3(clk_out_1_3),
        .clk_out_2_3(clk_out_2_3),
        .clk_out_1_2(clk_out_1_2)
    );

    always #10 clk = ~clk;

    // Posedges seen since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    always @(posedge clk_out_1_3) if (rec) r13.push_back(longint'($time));
    always @(posedge clk_out_2_3) if (rec) r23.push_back(longint'($time));
    always @(posedge clk_out_1_2) if (rec) r12.push_back(longint'($time));
    always @(negedge clk_out_1_2) if (rec) f12.push_back(longint'($time));

    // {clk_out_1_2, clk_out_2_3, clk_out_1_3} after k posedges; after_neg = clk currently low
    function automatic logic [2:0] model(int kk, bit after_neg);
        logic one_third, hold;
        one_third = (kk >= 3) && (kk % 3 == 0);
        hold = after_neg ? one_third : ((kk >= 4) && ((kk - 1) % 3 == 0));
        return {one_third | hold, (kk >= 1) && (kk % 3 != 0), one_third};
    endfunction

    task automatic test_reset();
        #5;
        checks++;
        if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pre_edge: got %b want 000", {clk_out_1_2, clk_out_2_3, clk_out_1_3});
        end
        #10;
        checks++;
        if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== 3'b000) begin
            errors++;
            $display("FAIL reset_post_edge: got %b want 000", {clk_out_1_2, clk_out_2_3, clk_out_1_3});
        end
        #5 rst_n = 1'b1;
    endtask

    task automatic test_duty();
        logic e13, e23, e12;
        longint t;
        #5;
        while ($time < 230) begin
            t = longint'($time);
            e13 = (t > 70 && t < 90) || (t > 130 && t < 150) || (t > 190 && t < 210);
            e23 = (t > 30 && t < 70) || (t > 90 && t < 130) || (t > 150 && t < 190) || (t > 210 && t < 250);
            e12 = (t > 70 && t < 100) || (t > 130 && t < 160) || (t > 190 && t < 220);
            checks++;
            if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== {e12, e23, e13}) begin
                errors++;
                $display("FAIL duty_t%0d: got %b want %b", t, {clk_out_1_2, clk_out_2_3, clk_out_1_3}, {e12, e23, e13});
            end
            #10;
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #15 rst_n = 1'b0;
        #1;
        checks++;
        if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 000", {clk_out_1_2, clk_out_2_3, clk_out_1_3});
        end
        #19 rst_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #5;
            checks++;
            if ({clk_out_2_3, clk_out_1_3} !== {(j % 3 != 0), (j % 3 == 0)}) begin
                errors++;
                $display("FAIL mid_reset_edge%0d: got %b want %b", j, {clk_out_2_3, clk_out_1_3}, {(j % 3 != 0), (j % 3 == 0)});
            end
        end
    endtask

    task automatic test_random();
        int off;
        for (int it = 0; it < 40; it++) begin
            for (int c = $urandom_range(12, 1); c > 0; c--) begin
                @(posedge clk);
                #5;
                checks++;
                if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== model(k, 1'b0)) begin
                    errors++;
                    $display("FAIL rand_hi it%0d k%0d: got %b want %b", it, k, {clk_out_1_2, clk_out_2_3, clk_out_1_3}, model(k, 1'b0));
                end
                if (k >= 1) begin
                    checks++;
                    if (clk_out_1_3 !== ~clk_out_2_3) begin
                        errors++;
                        $display("FAIL rand_compl it%0d k%0d: got %b/%b want complements", it, k, clk_out_1_3, clk_out_2_3);
                    end
                end
                @(negedge clk);
                #5;
                checks++;
                if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== model(k, 1'b1)) begin
                    errors++;
                    $display("FAIL rand_lo it%0d k%0d: got %b want %b", it, k, {clk_out_1_2, clk_out_2_3, clk_out_1_3}, model(k, 1'b1));
                end
            end
            if ($urandom_range(2, 0) == 0) begin
                off = $urandom_range(4, 0) + ($urandom_range(1, 0) ? 13 : 3);
                @(posedge clk);
                #off rst_n = 1'b0;
                #1;
                checks++;
                if ({clk_out_1_2, clk_out_2_3, clk_out_1_3} !== 3'b000) begin
                    errors++;
                    $display("FAIL rand_reset it%0d: got %b want 000", it, {clk_out_1_2, clk_out_2_3, clk_out_1_3});
                end
                #(20 * $urandom_range(3, 1)) rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_periods();
        @(posedge clk);
        #5 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        rec = 1'b1;
        #500;
        rec = 1'b0;
        checks++;
        if (r13.size() < 7 || r23.size() < 7 || r12.size() < 7 || f12.size() < 7) begin
            errors++;
            $display("FAIL period_count: got %0d/%0d/%0d/%0d edges want >=7 each", r13.size(), r23.size(), r12.size(), f12.size());
        end
        for (int i = 1; i < r13.size(); i++) begin
            checks++;
            if (r13[i] - r13[i-1] != 60) begin
                errors++;
                $display("FAIL period_1_3 #%0d: got %0d want 60", i, r13[i] - r13[i-1]);
            end
        end
        for (int i = 1; i < r23.size(); i++) begin
            checks++;
            if (r23[i] - r23[i-1] != 60) begin
                errors++;
                $display("FAIL period_2_3 #%0d: got %0d want 60", i, r23[i] - r23[i-1]);
            end
        end
        for (int i = 1; i < r12.size(); i++) begin
            checks++;
            if (r12[i] - r12[i-1] != 60) begin
                errors++;
                $display("FAIL period_1_2 #%0d: got %0d want 60", i, r12[i] - r12[i-1]);
            end
        end
        for (int i = 0; i < r12.size() && i < f12.size(); i++) begin
            checks++;
            if (f12[i] - r12[i] != 30) begin
                errors++;
                $display("FAIL high_1_2 #%0d: got %0d want 30", i, f12[i] - r12[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_mid_reset();
        test_random();
        test_periods();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
